// File: rtl/seg_mux_driver.sv
// seg_mux_driver: time-multiplexed N-digit seven-segment driver.
// Each digit owns one slot of 2^SWITCH_SPEED clocks. New display contents go
// into a shadow buffer and move to the active set only on a frame boundary,
// so a frame never shows a mix of old and new contents. A slot starts with
// a few blank clocks (anti-ghosting). PWM brightness, per-digit blink, decimal
// points and leading-zero suppression are then applied.
module seg_mux_driver #(
  parameter int DIGITS          = 4,
  parameter int ONLY_DIGITS     = 1,
  parameter int SWITCH_SPEED    = 7,
  parameter int BRIGHT_BITS     = 4,
  parameter int BLANK_CYCLES    = 2,
  parameter int BLINK_SPEED     = 22,
  parameter int INVERT_ANODES   = 0,
  parameter int INVERT_CATHODES = 0
) (
  input  logic                                           i_Clock,
  input  logic                                           i_Reset,
  input  logic [DIGITS*((ONLY_DIGITS != 0) ? 4 : 8)-1:0] i_Data,
  input  logic [DIGITS-1:0]                              i_DP,
  input  logic [DIGITS-1:0]                              i_Blink,
  input  logic                                           i_Suppress,
  input  logic [BRIGHT_BITS-1:0]                         i_Brightness,
  input  logic                                           i_Load,
  output logic                                           o_Ready,
  output logic                                           o_Frame,
  output logic [DIGITS-1:0]                              o_Anodes,
  output logic [7:0]                                     o_Cathodes
);

  localparam int CODE_W  = (ONLY_DIGITS != 0) ? 4 : 8;
  localparam int DATA_W  = DIGITS * CODE_W;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BLINK_W = BLINK_SPEED + 1;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [SWITCH_SPEED-1:0] SLOT_MAX = {SWITCH_SPEED{1'b1}};
  localparam logic [SWITCH_SPEED-1:0] BLANK_C  = SWITCH_SPEED'(BLANK_CYCLES);
  localparam logic [DIGITS-1:0]       ANODE_OFF = (INVERT_ANODES != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]              CATH_OFF  = (INVERT_CATHODES != 0) ? 8'hFF : 8'h00;

  // Hex digit to segment image {dp, g, f, e, d, c, b, a}; dp never set here.
  function automatic logic [7:0] seg7_dig(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'h0:    seg = 8'h3F;
      4'h1:    seg = 8'h06;
      4'h2:    seg = 8'h5B;
      4'h3:    seg = 8'h4F;
      4'h4:    seg = 8'h66;
      4'h5:    seg = 8'h6D;
      4'h6:    seg = 8'h7D;
      4'h7:    seg = 8'h07;
      4'h8:    seg = 8'h7F;
      4'h9:    seg = 8'h6F;
      4'hA:    seg = 8'h77;
      4'hB:    seg = 8'h7C;
      4'hC:    seg = 8'h39;
      4'hD:    seg = 8'h5E;
      4'hE:    seg = 8'h79;
      4'hF:    seg = 8'h71;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

  // Symbol codes are already segment images {dp, g..a}; pass them through.
  function automatic logic [7:0] seg7_sym(input logic [7:0] sym);
    return sym;
  endfunction

  // Scan counters
  logic [SWITCH_SPEED-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    boundary_s;

  // Load handshake: shadow and active sets
  logic                   ready_q, ready_d;
  logic                   frame_q, frame_d;
  logic                   capture_s, transfer_s;
  logic [DATA_W-1:0]      shd_data_q, shd_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]      shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]      shd_blink_q, shd_blink_d, act_blink_q, act_blink_d;
  logic                   shd_sup_q, shd_sup_d, act_sup_q, act_sup_d;
  logic [BRIGHT_BITS-1:0] shd_bright_q, shd_bright_d, act_bright_q, act_bright_d;

  // Display path
  logic [7:0]        code_s, enc_s, cath_s;
  logic              dp_s, blink_s, supp_s, lit_s;
  logic [DIGITS-1:0] anode_s;
  logic [DIGITS-1:0] anodes_q, anodes_d;
  logic [7:0]        cathodes_q, cathodes_d;

  // Slot counter, digit index and blink counter; frame boundary detect.
  always_comb begin
    slot_d      = slot_q + SWITCH_SPEED'(1);
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    boundary_s  = (slot_q == {SWITCH_SPEED{1'b0}}) && (idx_q == {IDX_W{1'b0}});
    frame_d     = boundary_s;
    if (slot_q == SLOT_MAX) begin
      if (idx_q == LAST_IDX) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Shadow capture while free; shadow-to-active transfer on a frame boundary.
  // A capture can only happen with ready_q=1 and a transfer only with
  // ready_q=0, so a capture on a boundary clock waits for the next boundary.
  always_comb begin
    capture_s    = i_Load && ready_q;
    transfer_s   = boundary_s && !ready_q;
    shd_data_d   = shd_data_q;
    shd_dp_d     = shd_dp_q;
    shd_blink_d  = shd_blink_q;
    shd_sup_d    = shd_sup_q;
    shd_bright_d = shd_bright_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blink_d  = act_blink_q;
    act_sup_d    = act_sup_q;
    act_bright_d = act_bright_q;
    ready_d      = ready_q;
    if (capture_s) begin
      shd_data_d   = i_Data;
      shd_dp_d     = i_DP;
      shd_blink_d  = i_Blink;
      shd_sup_d    = i_Suppress;
      shd_bright_d = i_Brightness;
      ready_d      = 1'b0;
    end else if (transfer_s) begin
      act_data_d   = shd_data_q;
      act_dp_d     = shd_dp_q;
      act_blink_d  = shd_blink_q;
      act_sup_d    = shd_sup_q;
      act_bright_d = shd_bright_q;
      ready_d      = 1'b1;
    end else begin
      ready_d      = ready_q;
    end
  end

  // Select the current digit, apply suppression, PWM, blank and blink gating.
  always_comb begin : display_path
    logic zero_run;
    zero_run = 1'b1;
    code_s   = 8'h00;
    dp_s     = 1'b0;
    blink_s  = 1'b0;
    supp_s   = 1'b0;
    anode_s  = {DIGITS{1'b0}};
    // Walk from the most significant digit down: zero_run stays set while
    // this digit and every higher one hold code 0.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      logic sel;
      sel      = (idx_q == IDX_W'(i));
      zero_run = zero_run & (act_data_q[i*CODE_W +: CODE_W] == {CODE_W{1'b0}});
      code_s   = code_s | ({8{sel}} & 8'(act_data_q[i*CODE_W +: CODE_W]));
      dp_s     = dp_s | (sel & act_dp_q[i]);
      blink_s  = blink_s | (sel & act_blink_q[i]);
      supp_s   = supp_s | (sel & zero_run & (i != 0) & act_sup_q & (ONLY_DIGITS != 0));
    end
    lit_s = (slot_q >= BLANK_C)
         && (slot_q[SWITCH_SPEED-1 -: BRIGHT_BITS] < act_bright_q)
         && !(blink_s && blink_cnt_q[BLINK_SPEED]);
    for (int i = 0; i < DIGITS; i++) begin
      anode_s[i] = lit_s && (idx_q == IDX_W'(i));
    end
    if (ONLY_DIGITS != 0) begin
      enc_s = seg7_dig(code_s[3:0]);
    end else begin
      enc_s = seg7_sym(code_s);
    end
    cath_s = {dp_s | enc_s[7], supp_s ? 7'h00 : enc_s[6:0]};
  end

  // Apply pin polarity ahead of the output registers.
  always_comb begin
    if (INVERT_ANODES != 0) begin
      anodes_d = ~anode_s;
    end else begin
      anodes_d = anode_s;
    end
    if (INVERT_CATHODES != 0) begin
      cathodes_d = ~cath_s;
    end else begin
      cathodes_d = cath_s;
    end
  end

  // State and output registers with synchronous reset; reset drops any pending shadow.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      slot_q       <= {SWITCH_SPEED{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      blink_cnt_q  <= {BLINK_W{1'b0}};
      ready_q      <= 1'b1;
      frame_q      <= 1'b0;
      shd_data_q   <= {DATA_W{1'b0}};
      shd_dp_q     <= {DIGITS{1'b0}};
      shd_blink_q  <= {DIGITS{1'b0}};
      shd_sup_q    <= 1'b0;
      shd_bright_q <= {BRIGHT_BITS{1'b0}};
      act_data_q   <= {DATA_W{1'b0}};
      act_dp_q     <= {DIGITS{1'b0}};
      act_blink_q  <= {DIGITS{1'b0}};
      act_sup_q    <= 1'b0;
      act_bright_q <= {BRIGHT_BITS{1'b1}};
      anodes_q     <= ANODE_OFF;
      cathodes_q   <= CATH_OFF;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      ready_q      <= ready_d;
      frame_q      <= frame_d;
      shd_data_q   <= shd_data_d;
      shd_dp_q     <= shd_dp_d;
      shd_blink_q  <= shd_blink_d;
      shd_sup_q    <= shd_sup_d;
      shd_bright_q <= shd_bright_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blink_q  <= act_blink_d;
      act_sup_q    <= act_sup_d;
      act_bright_q <= act_bright_d;
      anodes_q     <= anodes_d;
      cathodes_q   <= cathodes_d;
    end
  end

  assign o_Ready    = ready_q;
  assign o_Frame    = frame_q;
  assign o_Anodes   = anodes_q;
  assign o_Cathodes = cathodes_q;

endmodule
